// File: rtl/prng_share_arbiter_if.sv
`timescale 1ns/1ps
// prng_share_arbiter_if
// Bundles the requester handshakes, reseed handshake and lfsr_prng pins of
// prng_share_arbiter.
//   slave  : arbiter side (drives grants, responses, PRNG control).
//   master : environment side (requesters, reseed source, PRNG data).
// Ports of the bundle:
//   req_valid/req_ready  [NUM_REQ]    : per-requester draw handshake
//   rsp_valid [NUM_REQ], rsp_data     : registered one-hot response + word
//   seed_valid/seed_data/seed_ready   : reseed handshake
//   prng_load/prng_seed/prng_enable   : control towards lfsr_prng
//   prng_data                         : lfsr_prng.data_out
interface prng_share_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  seed_valid;
    logic [DATA_WIDTH-1:0] seed_data;
    logic                  seed_ready;
    logic                  prng_load;
    logic [DATA_WIDTH-1:0] prng_seed;
    logic                  prng_enable;
    logic [DATA_WIDTH-1:0] prng_data;

    modport slave (
        input  req_valid, seed_valid, seed_data, prng_data,
        output req_ready, rsp_valid, rsp_data, seed_ready,
               prng_load, prng_seed, prng_enable
    );

    modport master (
        output req_valid, seed_valid, seed_data, prng_data,
        input  req_ready, rsp_valid, rsp_data, seed_ready,
               prng_load, prng_seed, prng_enable
    );
endinterface

// File: rtl/prng_share_arbiter.sv
`timescale 1ns/1ps
// prng_share_arbiter
// Shares one lfsr_prng among NUM_REQ requesters. Draws are granted
// round-robin (one word per cycle, response registered one cycle later),
// reseed requests take priority over draws, and a zero seed is replaced by
// SEED so the PRNG can never lock up at the all-zero state.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : prng_share_arbiter_if.slave (handshakes + PRNG pins)
//   stat_draws : granted-draw counter, present only when PRNG_ARB_STATS_EN
//                is defined
// Optional feature macro: PRNG_ARB_STATS_EN
module prng_share_arbiter #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0] SEED      = DATA_WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    prng_share_arbiter_if.slave    bus
`ifdef PRNG_ARB_STATS_EN
    ,
    output logic [31:0]            stat_draws
`endif
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAST_REQ = NUM_REQ - 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESEED = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  draw;
    logic                  seed_take;

    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  seed_ready_c;
    logic                  prng_load_c;
    logic                  prng_enable_c;
    logic [DATA_WIDTH-1:0] prng_seed_c;

    // Round-robin search: first asserted req_valid at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[PTR_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and PRNG/handshake control; seeds win over draws.
    always_comb begin
        state_nxt     = state;
        req_ready_c   = '0;
        seed_ready_c  = 1'b0;
        prng_load_c   = 1'b0;
        prng_enable_c = 1'b0;
        prng_seed_c   = '0;
        draw          = 1'b0;
        seed_take     = 1'b0;
        case (state)
            ST_INIT: begin
                prng_load_c = 1'b1;
                prng_seed_c = SEED;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (bus.seed_valid) begin
                    seed_ready_c = 1'b1;
                    seed_take    = 1'b1;
                    state_nxt    = ST_RESEED;
                end else if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    prng_enable_c          = 1'b1;
                    draw                   = 1'b1;
                end
            end
            ST_RESEED: begin
                prng_load_c = 1'b1;
                prng_seed_c = seed_q;
                state_nxt   = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign bus.req_ready   = rst ? '0   : req_ready_c;
    assign bus.seed_ready  = rst ? 1'b0 : seed_ready_c;
    assign bus.prng_load   = rst ? 1'b0 : prng_load_c;
    assign bus.prng_enable = rst ? 1'b0 : prng_enable_c;
    assign bus.prng_seed   = rst ? '0   : prng_seed_c;

    // Response register, round-robin pointer and latched seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            seed_q        <= SEED;
        end else begin
            bus.rsp_valid <= '0;
            if (draw) begin
                bus.rsp_valid <= NUM_REQ'(1) << grant_idx;
                bus.rsp_data  <= bus.prng_data;
                rr_ptr        <= (grant_idx == PTR_W'(LAST_REQ)) ? '0
                                                                 : grant_idx + PTR_W'(1);
            end
            if (seed_take) begin
                seed_q <= (bus.seed_data == '0) ? SEED : bus.seed_data;
            end
        end
    end

`ifdef PRNG_ARB_STATS_EN
    // Saturating draw counter, cleared when a seed is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_draws <= '0;
        end else if (seed_take) begin
            stat_draws <= '0;
        end else if (draw && (stat_draws != 32'hFFFF_FFFF)) begin
            stat_draws <= stat_draws + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prng_share_arbiter.sv
`timescale 1ns/1ps
module tb_prng_share_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 4;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prng_share_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef PRNG_ARB_STATS_EN
    logic [31:0] stat_draws;
`endif

    prng_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PRNG_ARB_STATS_EN
        ,
        .stat_draws (stat_draws)
`endif
    );

    // Golden PRNG step: Galois right-shift LFSR, never reaches zero from non-zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Stand-in lfsr_prng driven by the DUT's control pins.
    logic [31:0] prng_st = 32'h0;
    always @(posedge clk) begin
        if (bus.prng_load)        prng_st <= bus.prng_seed;
        else if (bus.prng_enable) prng_st <= lfsr_next(prng_st);
    end
    assign bus.prng_data = prng_st;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model (phase: 0 init, 1 run, 2 reseed).
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [31:0] m_seed_q   = SEED;
    logic [31:0] m_gold     = SEED;
    logic [3:0]  m_rsp_valid = '0;
    logic [31:0] m_rsp_data  = '0;
    logic [31:0] m_stats     = '0;

    logic [3:0]  a_rv;
    logic        a_sv;
    logic [31:0] a_sd;

    logic [3:0]  e_req_ready;
    logic        e_seed_ready, e_load, e_enable;
    logic [31:0] e_seed;
    int          e_win;

    function automatic logic [74:0] obs();
        return {bus.req_ready, bus.seed_ready, bus.prng_load, bus.prng_enable,
                bus.prng_seed, bus.rsp_valid, bus.rsp_data};
    endfunction

    function automatic logic [74:0] expv();
        return {e_req_ready, e_seed_ready, e_load, e_enable,
                e_seed, m_rsp_valid, m_rsp_data};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_seed_q = SEED;
        m_rsp_valid = '0; m_rsp_data = '0; m_stats = '0;
    endtask

    // Drive one cycle's inputs (at posedge+1) and settle to posedge+4.
    task automatic apply(input logic [3:0] rv, input logic sv, input logic [31:0] sd);
        a_rv = rv; a_sv = sv; a_sd = sd;
        bus.req_valid = rv; bus.seed_valid = sv; bus.seed_data = sd;
        e_req_ready = '0; e_seed_ready = 0; e_load = 0; e_enable = 0; e_seed = '0; e_win = -1;
        if (!rst) begin
            if (m_phase == 0) begin
                e_load = 1; e_seed = SEED;
            end else if (m_phase == 2) begin
                e_load = 1; e_seed = m_seed_q;
            end else if (sv) begin
                e_seed_ready = 1;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_ptr + k) % NR;
                    if (e_win < 0 && rv[i]) e_win = i;
                end
                if (e_win >= 0) begin
                    e_req_ready = 4'(1) << e_win;
                    e_enable = 1;
                end
            end
        end
        #3;
    endtask

    // Advance the model across the clock edge; return at posedge+1.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_gold = SEED; m_phase = 1; m_rsp_valid = '0;
        end else if (m_phase == 2) begin
            m_gold = m_seed_q; m_phase = 1; m_rsp_valid = '0;
        end else if (a_sv) begin
            m_seed_q = (a_sd == 0) ? SEED : a_sd;
            m_phase = 2; m_rsp_valid = '0; m_stats = '0;
        end else if (e_win >= 0) begin
            m_rsp_valid = 4'(1) << e_win;
            m_rsp_data  = m_gold;
            m_gold      = lfsr_next(m_gold);
            m_ptr       = (e_win + 1) % NR;
            if (m_stats != 32'hFFFF_FFFF) m_stats = m_stats + 1;
        end else begin
            m_rsp_valid = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        apply(4'h0, 0, 32'h0);
        tick();
        rst = 0;
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(4'($urandom), 1'($urandom), $urandom);
            n_checks++;
            if (obs() !== 75'b0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: got %h want 0", c, obs());
            end
            tick();
        end
        rst = 0;
        apply(4'h0, 0, 32'h0);
        n_checks++;
        if (obs() !== expv() || bus.prng_load !== 1'b1 || bus.prng_seed !== SEED) begin
            n_fail++;
            $display("FAIL reset_init: got %h want %h", obs(), expv());
        end
        tick();
        apply(4'h0, 0, 32'h0);
        n_checks++;
        if (obs() !== 75'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 0", obs());
        end
        tick();
    endtask

    task automatic test_single();
        logic [31:0] g;
        do_reset();
        g = SEED;
        for (int c = 0; c < 3; c++) begin
            apply(4'b0001, 0, 32'h0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", c, obs(), expv());
            end
            tick();
            n_checks++;
            if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== g) begin
                n_fail++;
                $display("FAIL single_rsp c%0d: got %b/%h want 0001/%h",
                         c, bus.rsp_valid, bus.rsp_data, g);
            end
            g = lfsr_next(g);
        end
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_all_four();
        logic [31:0] words[$];
        logic [31:0] g;
        int dups;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(4'hF, 0, 32'h0);
            n_checks++;
            if (obs() !== expv() || bus.req_ready !== (4'(1) << (c % 4))) begin
                n_fail++;
                $display("FAIL all_four c%0d: got %h want %h", c, obs(), expv());
            end
            tick();
            words.push_back(bus.rsp_data);
        end
        dups = 0;
        g = SEED;
        for (int i = 0; i < words.size(); i++) begin
            if (words[i] !== g) dups++;
            for (int j = i + 1; j < words.size(); j++)
                if (words[i] === words[j]) dups++;
            g = lfsr_next(g);
        end
        n_checks++;
        if (dups != 0) begin
            n_fail++;
            $display("FAIL all_four_order: got %0d bad words want 0", dups);
        end
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_reseed();
        apply(4'hF, 1, 32'hDEAD_BEEF);
        n_checks++;
        if (obs() !== expv() || bus.seed_ready !== 1'b1 || bus.req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL reseed_accept: got %h want %h", obs(), expv());
        end
        tick();
        apply(4'hF, 0, 32'h0);
        n_checks++;
        if (obs() !== expv() || bus.prng_load !== 1'b1 || bus.prng_seed !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL reseed_load: got %h want %h", obs(), expv());
        end
        tick();
        apply(4'hF, 0, 32'h0);
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reseed_grant: got %h want %h", obs(), expv());
        end
        tick();
        n_checks++;
        if (bus.rsp_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL reseed_word: got %h want deadbeef", bus.rsp_data);
        end
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_zero_seed();
        apply(4'($urandom), 1, 32'h0);
        tick();
        apply(4'h0, 0, 32'h0);
        n_checks++;
        if (obs() !== expv() || bus.prng_seed !== SEED) begin
            n_fail++;
            $display("FAIL zero_seed_load: got %h want %h", obs(), expv());
        end
        tick();
        apply(4'b0100, 0, 32'h0);
        tick();
        n_checks++;
        if (bus.rsp_data !== SEED || bus.rsp_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL zero_seed_word: got %b/%h want 0100/%h",
                     bus.rsp_valid, bus.rsp_data, SEED);
        end
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(4'b0001, 0, 32'h0);
        tick();
        apply(4'b0010, 0, 32'h0);
        tick();
        apply(4'h0, 0, 32'h0);
        n_checks++;
        if (obs() !== expv() || bus.rsp_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_pending: got %h want %h", obs(), expv());
        end
        rst = 1;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 75'b0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: got %h want 0", obs());
        end
        tick();
        rst = 0;
        apply(4'h0, 0, 32'h0);
        n_checks++;
        if (obs() !== expv() || bus.prng_load !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reinit: got %h want %h", obs(), expv());
        end
`ifdef PRNG_ARB_STATS_EN
        n_checks++;
        if (stat_draws !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d want 0", stat_draws);
        end
`endif
        tick();
        for (int c = 0; c < 5; c++) begin
            apply(4'($urandom_range(1, 15)), 0, 32'h0);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL mid_grant c%0d: got %h want %h", c, obs(), expv());
            end
            tick();
        end
`ifdef PRNG_ARB_STATS_EN
        n_checks++;
        if (stat_draws !== 32'd5) begin
            n_fail++;
            $display("FAIL stats_count: got %0d want 5", stat_draws);
        end
`endif
        apply(4'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic sv;
            logic [31:0] sd;
            sv = ($urandom_range(0, 15) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            apply(4'($urandom), sv, sd);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, obs(), expv());
            end
`ifdef PRNG_ARB_STATS_EN
            n_checks++;
            if (stat_draws !== m_stats) begin
                n_fail++;
                $display("FAIL random_stats c%0d: got %0d want %0d", c, stat_draws, m_stats);
            end
`endif
            tick();
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.seed_valid = 1'b0;
        bus.seed_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_four();
        test_reseed();
        test_zero_seed();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
